// File: rtl/test_dma_pkg.sv
// Shared types and defaults for the test-memory DMA initiator.
package test_dma_pkg;

  localparam int PATTERN_WIDTH_DEFAULT  = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_XFER   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  function automatic logic [23:0] min24(input logic [23:0] a, input logic [23:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/test_dma_initiator_if.sv
// DMA port between the initiator (master) and the test memory device (slave).
// Handshake: a word moves on every cycle *_strobe is high while *_activate is high; the device
// raises *_ready when a buffer can be claimed and the initiator claims it by raising *_activate.
interface test_dma_initiator_if;
  logic        write_enable;
  logic [63:0] write_addr;
  logic        write_addr_inc;
  logic        write_addr_dec;
  logic [23:0] write_count;
  logic        write_flush;
  logic [1:0]  write_ready;
  logic [1:0]  write_activate;
  logic [23:0] write_size;
  logic        write_strobe;
  logic [31:0] write_data;
  logic        write_finished;

  logic        read_enable;
  logic [63:0] read_addr;
  logic        read_addr_inc;
  logic        read_addr_dec;
  logic [23:0] read_count;
  logic        read_flush;
  logic        read_ready;
  logic        read_activate;
  logic [23:0] read_size;
  logic [31:0] read_data;
  logic        read_strobe;
  logic        read_busy;
  logic        read_error;

  modport master (
    output write_enable, write_addr, write_addr_inc, write_addr_dec, write_count, write_flush,
           write_activate, write_strobe, write_data,
           read_enable, read_addr, read_addr_inc, read_addr_dec, read_count, read_flush,
           read_activate, read_strobe,
    input  write_ready, write_size, write_finished,
           read_ready, read_size, read_data, read_busy, read_error
  );

  modport slave (
    input  write_enable, write_addr, write_addr_inc, write_addr_dec, write_count, write_flush,
           write_activate, write_strobe, write_data,
           read_enable, read_addr, read_addr_inc, read_addr_dec, read_count, read_flush,
           read_activate, read_strobe,
    output write_ready, write_size, write_finished,
           read_ready, read_size, read_data, read_busy, read_error
  );
endinterface

// File: rtl/test_dma_initiator_pattern_gen.sv
// Incrementing pattern source: loads a seed, advances by one, wraps mod 2**WIDTH.
module pattern_gen
  import test_dma_pkg::*;
#(
  parameter int WIDTH = PATTERN_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/test_dma_initiator.sv
// DMA initiator for the test memory device: streams a pattern on writes, checks it on reads.
module test_dma_initiator
  import test_dma_pkg::*;
#(
  parameter int PATTERN_WIDTH  = PATTERN_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_read,
  input  logic [63:0] cmd_addr,
  input  logic [23:0] cmd_count,
  input  logic        cmd_inc,
  input  logic        cmd_dec,
  input  logic [31:0] cmd_seed,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [23:0] word_count,
  output state_t      fsm_state,
  test_dma_initiator_if.master dma
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t      state_q, state_d;
  logic        is_read, inc_q, dec_q;
  logic [63:0] addr_q;
  logic [23:0] count_q, remaining, burst_left, wcount_q;
  logic [1:0]  wr_act;
  logic        rd_act;
  logic [TW-1:0] tmo_cnt;
  logic        done_q, done_d, timeout_q, wflush_q, rflush_q;
  logic [15:0] err_q;
  logic [16:0] err_sum;
  logic [1:0]  err_inc;
  logic [23:0] burst_len;
  logic [PATTERN_WIDTH-1:0] wr_pat, rd_pat;
  logic start, waiting, wr_strobe, rd_strobe, strobe, wr_grab, rd_grab;
  logic finish_ok, progress, expired, mismatch, wr_txn, rd_txn;
  logic unused_inputs;

  assign unused_inputs = ^{dma.read_busy, cmd_seed};

  assign start     = cmd_start && (state_q == ST_IDLE);
  assign waiting   = (state_q == ST_XFER) || (state_q == ST_FINISH);
  assign wr_strobe = (state_q == ST_XFER) && !is_read && (wr_act != 2'b00) && (burst_left != 24'd0);
  assign rd_strobe = (state_q == ST_XFER) && is_read && rd_act && (burst_left != 24'd0);
  assign strobe    = wr_strobe || rd_strobe;
  assign wr_grab   = (state_q == ST_XFER) && !is_read && (wr_act == 2'b00) && (dma.write_ready != 2'b00)
                     && (dma.write_size != 24'd0) && (remaining != 24'd0);
  assign rd_grab   = (state_q == ST_XFER) && is_read && !rd_act && dma.read_ready
                     && (dma.read_size != 24'd0) && (remaining != 24'd0);
  // Never claim more words than the command still needs.
  assign burst_len = min24(is_read ? dma.read_size : dma.write_size, remaining);
  assign finish_ok = (state_q == ST_FINISH) && (is_read || dma.write_finished);
  assign progress  = strobe || wr_grab || rd_grab || finish_ok;
  assign expired   = waiting && !progress && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign mismatch  = rd_strobe && (dma.read_data != 32'(rd_pat));
  assign err_inc   = {1'b0, mismatch} + {1'b0, dma.read_error && (state_q != ST_IDLE)};
  assign err_sum   = {1'b0, err_q} + {15'd0, err_inc};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_start) state_d = ST_REQ;
      ST_REQ: begin
        if (count_q == 24'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (expired) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if ((remaining == 24'd0) && (wr_act == 2'b00) && !rd_act) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (expired || finish_ok) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_read    <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      remaining  <= '0;
      burst_left <= '0;
      wcount_q   <= '0;
      wr_act     <= '0;
      rd_act     <= 1'b0;
      tmo_cnt    <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wflush_q   <= 1'b0;
      rflush_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      done_q   <= done_d;
      wflush_q <= expired && !is_read;
      rflush_q <= expired && is_read;
      if (start) begin
        is_read    <= cmd_read;
        inc_q      <= cmd_inc;
        dec_q      <= cmd_dec && !cmd_inc;
        addr_q     <= cmd_addr;
        count_q    <= cmd_count;
        remaining  <= cmd_count;
        burst_left <= '0;
        wcount_q   <= '0;
        wr_act     <= '0;
        rd_act     <= 1'b0;
        tmo_cnt    <= '0;
        timeout_q  <= 1'b0;
        err_q      <= '0;
      end else begin
        tmo_cnt <= (progress || !waiting) ? '0 : tmo_cnt + TW'(1);
        err_q   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (expired) begin
          timeout_q <= 1'b1;
          wr_act    <= '0;
          rd_act    <= 1'b0;
        end
        if (wr_grab) begin
          wr_act     <= dma.write_ready[0] ? 2'b01 : 2'b10;
          burst_left <= burst_len;
        end
        if (rd_grab) begin
          rd_act     <= 1'b1;
          burst_left <= burst_len;
        end
        if (strobe) begin
          burst_left <= burst_left - 24'd1;
          remaining  <= remaining - 24'd1;
          wcount_q   <= wcount_q + 24'd1;
          if (burst_left == 24'd1) begin
            wr_act <= '0;
            rd_act <= 1'b0;
          end
        end
      end
    end
  end

  pattern_gen #(.WIDTH(PATTERN_WIDTH)) u_wr_pat (
    .clk(clk), .rst(rst), .load(start), .seed(cmd_seed[PATTERN_WIDTH-1:0]),
    .advance(wr_strobe), .value(wr_pat)
  );

  pattern_gen #(.WIDTH(PATTERN_WIDTH)) u_rd_pat (
    .clk(clk), .rst(rst), .load(start), .seed(cmd_seed[PATTERN_WIDTH-1:0]),
    .advance(rd_strobe), .value(rd_pat)
  );

  assign wr_txn = (state_q != ST_IDLE) && !is_read;
  assign rd_txn = (state_q != ST_IDLE) && is_read;

  assign dma.write_enable   = wr_txn;
  assign dma.write_addr     = wr_txn ? addr_q : '0;
  assign dma.write_addr_inc = wr_txn && inc_q;
  assign dma.write_addr_dec = wr_txn && dec_q;
  assign dma.write_count    = wr_txn ? count_q : '0;
  assign dma.write_flush    = wflush_q;
  assign dma.write_activate = wr_act;
  assign dma.write_strobe   = wr_strobe;
  assign dma.write_data     = wr_txn ? 32'(wr_pat) : '0;

  assign dma.read_enable    = rd_txn;
  assign dma.read_addr      = rd_txn ? addr_q : '0;
  assign dma.read_addr_inc  = rd_txn && inc_q;
  assign dma.read_addr_dec  = rd_txn && dec_q;
  assign dma.read_count     = rd_txn ? count_q : '0;
  assign dma.read_flush     = rflush_q;
  assign dma.read_activate  = rd_act;
  assign dma.read_strobe    = rd_strobe;

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign err_count  = err_q;
  assign word_count = wcount_q;
  assign fsm_state  = state_q;

endmodule
